lilmem_seq: RTL and testbench
=============================

# lilmem_seq

Block-transfer sequencer for one lilmem 4KB memory. ARM software issues a single command (fill, checksum, or verify over a word range) and the block drives lilmem's ARM register port word by word. It only issues lilmem register writes while the Unibus side is quiet, so PDP accesses are never delayed. It sits between the ARM register decoder and the lilmem ARM port; an external mux gives the sequencer ownership of that port while `lm_own` is high.

## Interface
- `NOTHING` — no parameters; memory size fixed at 2048 words.
- `CLOCK  in  1  system clock; all state changes on posedge`
- `RESET  in  1  asynchronous, active-low reset`
- `armwrite  in  1  ARM writing a sequencer register this cycle`
- `armraddr  in  2  ARM read register select`
- `armwaddr  in  2  ARM write register select`
- `armwdata  in  32  ARM write data`
- `armrdata  out  32  ARM read data (combinational from armraddr)`
- `msyn_in_h  in  1  Unibus MSYN, as seen by lilmem`
- `lm_ssyn_h  in  1  lilmem ssyn_out_h`
- `lm_armwrite  out  1  write strobe to lilmem`
- `lm_armwaddr  out  2  lilmem write register select (1 = pointer, 2 = data)`
- `lm_armwdata  out  32  lilmem write data`
- `lm_armraddr  out  2  constant 2 (lilmem dataval)`
- `lm_armrdata  in  32  lilmem read data`
- `lm_own  out  1  equals busy; mux select for the lilmem ARM port`

## Operation
- **Register 0 (read):** 32'h4C531001 ('LS', nreg code 1, version 001).
- **Register 1:**
  - Write: [11:01] start word, [27:16] count (0..2048).
  - Read: {4'b0, remaining[11:0], 4'b0, ptr[11:01], 1'b0}.
- **Register 2:**
  - Write: [15:00] seed, [31:16] step.
  - Read: {step, current value}.
- **Register 3:**
  - Write: [31] start, [30] abort, [1:0] op (0 = FILL, 1 = SUM, 2 = VERIFY, 3 = reserved and treated as SUM).
  - Read: {busy, done, aborted, 1'b0, errcnt[11:0], sum[15:0]}.
- Writes to registers 1 and 2 while busy are ignored. A start while busy is ignored. Abort while idle has no effect.
- **Start:**
  - Loads ptr = start word, remaining = count, value = seed.
  - Clears sum, errcnt, done, aborted.
  - If count = 0: done = 1 immediately, state stays IDLE.
  - Otherwise goes to PTR.
- Quiet = ~msyn_in_h | lm_ssyn_h.
- **FSM:**
  - **IDLE:** waits for start.
  - **PTR:** when quiet, lm_armwrite = 1, lm_armwaddr = 1, lm_armwdata = {20'b0, ptr, 1'b0}. Then goes to DATA (FILL) or SAMPLE (SUM/VERIFY). While not quiet, holds with no strobe.
  - **DATA:** when quiet, lm_armwrite = 1, lm_armwaddr = 2, lm_armwdata = {16'b0, value}. Then goes to NEXT.
  - **SAMPLE:** w = lm_armrdata[15:0] (lilmem dataval, valid one cycle after the pointer write).
    - sum <= sum + w (mod 2^16).
    - VERIFY: if w != value, errcnt <= errcnt + 1, saturating at 4095.
    - Goes to NEXT.
  - **NEXT:**
    - ptr <= ptr + 1 (mod 2048: word 2047 wraps to 0).
    - value <= value + step (mod 2^16).
    - remaining <= remaining − 1.
    - If remaining was 1: done <= 1, go to IDLE. Otherwise go to PTR.
- lm_armwrite is combinational from state & quiet & ~abort-write. It is never asserted in IDLE, SAMPLE or NEXT.
- **Abort** (register 3 write with [30] = 1 while busy):
  - Next state IDLE; aborted = 1, done = 0.
  - lm_armwrite is forced 0 in that cycle.
  - ptr, remaining, sum and errcnt are frozen for readback.
- Start and abort set in the same write: abort wins when busy; start wins when idle.
- The sequencer leaves lilmem's addrptr at the last word touched. Software must rewrite lilmem register 1 before direct access.

## Timing
- **Reset (RESET low, async):**
  - State IDLE; ptr, remaining, value, step, sum, errcnt = 0; done, aborted = 0.
  - lm_armwrite = 0, lm_armwaddr = 0, lm_armwdata = 0, lm_own = 0.
  - lm_armraddr = 2 always.
- A start write in cycle 0 enters PTR in cycle 1; busy = 1 from cycle 1.
- **Per word with the bus quiet:** 3 cycles. FILL is PTR, DATA, NEXT; SUM/VERIFY is PTR, SAMPLE, NEXT.
  - An N-word operation finishes with done = 1 visible at cycle 3N + 1.
- Each cycle the bus is not quiet in PTR or DATA adds one cycle. SAMPLE never stalls.
- A RESET assertion mid-operation aborts immediately with no further strobe. aborted stays 0 (reset values).

## Test plan
- **FILL:** start 0, count 4, seed 16'h1000, step 2 -> lilmem words 0..3 = 1000, 1002, 1004, 1006; 4 pointer and 4 data strobes; done at cycle 13.
- **SUM after that fill:** -> sum = 16'h400C, errcnt = 0.
- **VERIFY with seed 16'h1000, step 1:** -> errcnt = 3; sum unchanged from the SUM value.
- **Wrap and stall:**
  - Start word 2046, count 3 -> touches words 2046, 2047, 0; ptr reads 1 at end.
  - With msyn_in_h = 1 and lm_ssyn_h = 0 held 5 cycles during PTR -> no lm_armwrite for those cycles; completion delayed exactly 5 cycles.
- **Abort:** count 2048 FILL, abort at cycle 20 -> lm_armwrite low from that cycle on; aborted = 1, done = 0, remaining = 2042; further register 1/2 writes accepted.
- **count = 0 and reset:**
  - count = 0 -> done = 1 next cycle, no strobes.
  - RESET low mid-FILL -> all outputs zero asynchronously; lm_own = 0.

Source files
------------

// File: rtl/lilmem_seq.sv
// Block-transfer sequencer for one lilmem 4KB memory: fill, checksum or verify a
// word range through lilmem's ARM register port, striking only while the Unibus is quiet.
module lilmem_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        armwrite,
  input  logic [1:0]  armraddr,
  input  logic [1:0]  armwaddr,
  input  logic [31:0] armwdata,
  output logic [31:0] armrdata,
  input  logic        msyn_in_h,
  input  logic        lm_ssyn_h,
  output logic        lm_armwrite,
  output logic [1:0]  lm_armwaddr,
  output logic [31:0] lm_armwdata,
  output logic [1:0]  lm_armraddr,
  input  logic [31:0] lm_armrdata,
  output logic        lm_own
);

  typedef enum logic [2:0] {S_IDLE, S_PTR, S_DATA, S_SAMPLE, S_NEXT} state_e;

  localparam logic [1:0]  OP_FILL   = 2'd0;
  localparam logic [1:0]  OP_VERIFY = 2'd2;
  localparam logic [11:0] ERR_MAX   = 12'hFFF;

  state_e      state_q, state_d;
  logic [10:0] ptr_q, ptr_d;
  logic [11:0] rem_q, rem_d;
  logic [15:0] value_q, value_d;
  logic [15:0] step_q, step_d;
  logic [15:0] sum_q, sum_d;
  logic [11:0] err_q, err_d;
  logic [1:0]  op_q, op_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  logic        busy, quiet, wr1, wr2, wr3, start_req, abort_req;
  logic [15:0] word_in;
  logic        unused_rdata_hi;

  assign busy      = (state_q != S_IDLE);
  assign quiet     = ~msyn_in_h | lm_ssyn_h;
  assign wr1       = armwrite && (armwaddr == 2'd1);
  assign wr2       = armwrite && (armwaddr == 2'd2);
  assign wr3       = armwrite && (armwaddr == 2'd3);
  assign start_req = wr3 && armwdata[31] && !busy;
  assign abort_req = wr3 && armwdata[30] && busy;
  assign word_in   = lm_armrdata[15:0];
  assign unused_rdata_hi = ^lm_armrdata[31:16];

  assign lm_own      = busy;
  assign lm_armraddr = 2'd2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: default assignment first so every path drives state_d; no latch is inferred.
    state_d = state_q;
    if (abort_req) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:   if (start_req && rem_q != 12'd0) state_d = S_PTR;
        S_PTR:    if (quiet) state_d = (op_q == OP_FILL) ? S_DATA : S_SAMPLE;
        S_DATA:   if (quiet) state_d = S_NEXT;
        S_SAMPLE: state_d = S_NEXT;
        S_NEXT:   state_d = (rem_q == 12'd1) ? S_IDLE : S_PTR;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Strobes only while the Unibus is quiet, and never in the cycle an abort lands.
  always_comb begin
    lm_armwrite = 1'b0;
    lm_armwaddr = 2'd0;
    lm_armwdata = 32'd0;
    if (quiet && !abort_req) begin
      if (state_q == S_PTR) begin
        lm_armwrite = 1'b1;
        lm_armwaddr = 2'd1;
        lm_armwdata = {20'd0, ptr_q, 1'b0};
      end else if (state_q == S_DATA) begin
        lm_armwrite = 1'b1;
        lm_armwaddr = 2'd2;
        lm_armwdata = {16'd0, value_q};
      end
    end
  end

  always_comb begin
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    value_d   = value_q;
    step_d    = step_q;
    sum_d     = sum_q;
    err_d     = err_q;
    op_d      = op_q;
    done_d    = done_q;
    aborted_d = aborted_q;
    if (!busy) begin
      if (wr1) begin
        ptr_d = armwdata[11:1];
        rem_d = armwdata[27:16];
      end
      if (wr2) begin
        value_d = armwdata[15:0];
        step_d  = armwdata[31:16];
      end
      if (start_req) begin
        op_d      = armwdata[1:0];
        sum_d     = 16'd0;
        err_d     = 12'd0;
        aborted_d = 1'b0;
        done_d    = (rem_q == 12'd0);
      end
    end else if (abort_req) begin
      aborted_d = 1'b1;
      done_d    = 1'b0;
    end else if (state_q == S_SAMPLE) begin
      sum_d = sum_q + word_in;
      if (op_q == OP_VERIFY && word_in != value_q && err_q != ERR_MAX) err_d = err_q + 12'd1;
    end else if (state_q == S_NEXT) begin
      ptr_d   = ptr_q + 11'd1;
      value_d = value_q + step_q;
      rem_d   = rem_q - 12'd1;
      if (rem_q == 12'd1) done_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      rem_q     <= '0;
      value_q   <= '0;
      step_q    <= '0;
      sum_q     <= '0;
      err_q     <= '0;
      op_q      <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      value_q   <= value_d;
      step_q    <= step_d;
      sum_q     <= sum_d;
      err_q     <= err_d;
      op_q      <= op_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    unique case (armraddr)
      2'd0:    armrdata = 32'h4C53_1001;
      2'd1:    armrdata = {4'd0, rem_q, 4'd0, ptr_q, 1'b0};
      2'd2:    armrdata = {step_q, value_q};
      default: armrdata = {busy, done_q, aborted_q, 1'b0, err_q, sum_q};
    endcase
  end

endmodule

// File: tb/tb_lilmem_seq.sv
// Directed bench for lilmem_seq with a small lilmem register-port model
// (address pointer plus word array, dataval combinational from the pointer).
module tb_lilmem_seq;

  logic        clk, rst_n;
  logic        armwrite;
  logic [1:0]  armraddr, armwaddr;
  logic [31:0] armwdata, armrdata;
  logic        msyn_in_h, lm_ssyn_h;
  logic        lm_armwrite;
  logic [1:0]  lm_armwaddr, lm_armraddr;
  logic [31:0] lm_armwdata, lm_armrdata;
  logic        lm_own;

  int errors = 0;
  int checks = 0;

  lilmem_seq dut (
    .clk(clk), .rst_n(rst_n),
    .armwrite(armwrite), .armraddr(armraddr), .armwaddr(armwaddr),
    .armwdata(armwdata), .armrdata(armrdata),
    .msyn_in_h(msyn_in_h), .lm_ssyn_h(lm_ssyn_h),
    .lm_armwrite(lm_armwrite), .lm_armwaddr(lm_armwaddr), .lm_armwdata(lm_armwdata),
    .lm_armraddr(lm_armraddr), .lm_armrdata(lm_armrdata), .lm_own(lm_own)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lilmem ARM port model
  logic [15:0] mem [0:2047];
  logic [10:0] lm_ptr = 11'd0;
  int ptr_strobes = 0;
  int data_strobes = 0;

  assign lm_armrdata = {16'h0, mem[lm_ptr]};

  always @(posedge clk) begin
    if (lm_armwrite) begin
      if (lm_armwaddr == 2'd1) begin
        lm_ptr <= lm_armwdata[11:1];
        ptr_strobes <= ptr_strobes + 1;
      end else if (lm_armwaddr == 2'd2) begin
        mem[lm_ptr] <= lm_armwdata[15:0];
        data_strobes <= data_strobes + 1;
      end
    end
  end

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    armwaddr = a;
    armwdata = d;
    armwrite = 1'b1;
    @(negedge clk);
    armwrite = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    armraddr = a;
    #1;
    d = armrdata;
  endtask

  task automatic wait_done(input int start_cyc, output int cyc);
    cyc = start_cyc;
    armraddr = 2'd3;
    #1;
    while (armrdata[30] !== 1'b1 && cyc < start_cyc + 6000) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (armrdata[30] !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: status=%h required done bit set", armrdata);
    end
  endtask

  task automatic test_reset;
    logic [31:0] r;
    read_reg(2'd0, r);
    checks++; if (r !== 32'h4C53_1001) begin errors++; $display("FAIL reset_id: got %h want %h", r, 32'h4C531001); end
    read_reg(2'd1, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_reg1: got %h want 0", r); end
    read_reg(2'd2, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_reg2: got %h want 0", r); end
    read_reg(2'd3, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", r); end
    checks++;
    if ({lm_armwrite, lm_own, lm_armwaddr, lm_armwdata} !== 36'h0) begin
      errors++; $display("FAIL reset_port: wr=%b own=%b waddr=%h wdata=%h want all 0",
                         lm_armwrite, lm_own, lm_armwaddr, lm_armwdata);
    end
    checks++; if (lm_armraddr !== 2'd2) begin errors++; $display("FAIL reset_raddr: got %0d want 2", lm_armraddr); end
  endtask

  task automatic test_fill;
    int p0, d0, cyc;
    logic [31:0] r;
    @(negedge clk);
    write_reg(2'd1, 32'h0004_0000);
    write_reg(2'd2, 32'h0002_1000);
    p0 = ptr_strobes; d0 = data_strobes;
    write_reg(2'd3, 32'h8000_0000);
    checks++; if (lm_own !== 1'b1) begin errors++; $display("FAIL fill_busy: own=%b want 1", lm_own); end
    wait_done(1, cyc);
    checks++; if (cyc != 13) begin errors++; $display("FAIL fill_done_cycle: got %0d want 13", cyc); end
    checks++;
    if (ptr_strobes - p0 != 4 || data_strobes - d0 != 4) begin
      errors++; $display("FAIL fill_strobes: ptr=%0d data=%0d want 4/4", ptr_strobes - p0, data_strobes - d0);
    end
    checks++;
    if ({mem[0], mem[1], mem[2], mem[3]} !== 64'h1000_1002_1004_1006) begin
      errors++; $display("FAIL fill_words: got %h %h %h %h want 1000 1002 1004 1006", mem[0], mem[1], mem[2], mem[3]);
    end
    read_reg(2'd1, r);
    checks++; if (r !== 32'h0000_0008) begin errors++; $display("FAIL fill_reg1: got %h want 00000008", r); end
    read_reg(2'd2, r);
    checks++; if (r !== 32'h0002_1008) begin errors++; $display("FAIL fill_reg2: got %h want 00021008", r); end
  endtask

  task automatic test_sum;
    int d0, cyc;
    logic [31:0] r;
    @(negedge clk);
    write_reg(2'd1, 32'h0004_0000);
    d0 = data_strobes;
    write_reg(2'd3, 32'h8000_0001);
    wait_done(1, cyc);
    checks++; if (cyc != 13) begin errors++; $display("FAIL sum_done_cycle: got %0d want 13", cyc); end
    read_reg(2'd3, r);
    checks++; if (r !== 32'h4000_400C) begin errors++; $display("FAIL sum_status: got %h want 4000400c", r); end
    checks++; if (data_strobes != d0) begin errors++; $display("FAIL sum_no_data: got %0d data strobes want 0", data_strobes - d0); end
  endtask

  task automatic test_verify;
    int cyc;
    logic [31:0] r;
    @(negedge clk);
    write_reg(2'd1, 32'h0004_0000);
    write_reg(2'd2, 32'h0001_1000);
    write_reg(2'd3, 32'h8000_0002);
    wait_done(1, cyc);
    read_reg(2'd3, r);
    checks++; if (r !== 32'h4003_400C) begin errors++; $display("FAIL verify_status: got %h want 4003400c", r); end
  endtask

  task automatic test_wrap_stall;
    int cyc, p0, d0;
    logic [31:0] r;
    @(negedge clk);
    write_reg(2'd1, 32'h0003_0FFC);
    write_reg(2'd2, 32'h0001_0005);
    p0 = ptr_strobes; d0 = data_strobes;
    write_reg(2'd3, 32'h8000_0000);
    msyn_in_h = 1'b1; lm_ssyn_h = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (lm_armwrite !== 1'b0) begin errors++; $display("FAIL stall_strobe: cycle %0d wr=%b want 0", k + 1, lm_armwrite); end
      @(negedge clk);
    end
    msyn_in_h = 1'b0;
    wait_done(6, cyc);
    checks++; if (cyc != 15) begin errors++; $display("FAIL stall_done_cycle: got %0d want 15", cyc); end
    checks++;
    if ({mem[2046], mem[2047], mem[0]} !== 48'h0005_0006_0007) begin
      errors++; $display("FAIL wrap_words: got %h %h %h want 0005 0006 0007", mem[2046], mem[2047], mem[0]);
    end
    checks++;
    if (ptr_strobes - p0 != 3 || data_strobes - d0 != 3) begin
      errors++; $display("FAIL wrap_strobes: ptr=%0d data=%0d want 3/3", ptr_strobes - p0, data_strobes - d0);
    end
    read_reg(2'd1, r);
    checks++; if (r !== 32'h0000_0002) begin errors++; $display("FAIL wrap_ptr: got %h want 00000002", r); end
  endtask

  task automatic test_abort;
    int p0, d0;
    logic [31:0] r;
    @(negedge clk);
    write_reg(2'd1, 32'h0800_0000);
    write_reg(2'd2, 32'h0001_0000);
    p0 = ptr_strobes; d0 = data_strobes;
    write_reg(2'd3, 32'h8000_0000);
    write_reg(2'd1, 32'h0001_0000);
    repeat (18) @(negedge clk);
    armwaddr = 2'd3; armwdata = 32'h4000_0000; armwrite = 1'b1;
    #1;
    checks++; if (lm_armwrite !== 1'b0) begin errors++; $display("FAIL abort_cycle_strobe: wr=%b want 0", lm_armwrite); end
    @(negedge clk);
    armwrite = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (lm_armwrite !== 1'b0 || lm_own !== 1'b0) begin
        errors++; $display("FAIL abort_after: wr=%b own=%b want 0/0", lm_armwrite, lm_own);
      end
      @(negedge clk);
    end
    checks++;
    if (ptr_strobes - p0 != 7 || data_strobes - d0 != 6) begin
      errors++; $display("FAIL abort_strobes: ptr=%0d data=%0d want 7/6", ptr_strobes - p0, data_strobes - d0);
    end
    read_reg(2'd1, r);
    checks++; if (r !== 32'h07FA_000C) begin errors++; $display("FAIL abort_reg1: got %h want 07fa000c", r); end
    read_reg(2'd3, r);
    checks++; if (r !== 32'h2000_0000) begin errors++; $display("FAIL abort_status: got %h want 20000000", r); end
    write_reg(2'd1, 32'h0002_0010);
    read_reg(2'd1, r);
    checks++; if (r !== 32'h0002_0010) begin errors++; $display("FAIL abort_rewrite: got %h want 00020010", r); end
  endtask

  task automatic test_count_zero;
    int p0, d0;
    logic [31:0] r;
    @(negedge clk);
    write_reg(2'd1, 32'h0000_0000);
    p0 = ptr_strobes; d0 = data_strobes;
    write_reg(2'd3, 32'h8000_0000);
    read_reg(2'd3, r);
    checks++; if (r !== 32'h4000_0000) begin errors++; $display("FAIL zero_status: got %h want 40000000", r); end
    repeat (3) @(negedge clk);
    checks++;
    if (ptr_strobes != p0 || data_strobes != d0) begin
      errors++; $display("FAIL zero_strobes: ptr=%0d data=%0d want 0/0", ptr_strobes - p0, data_strobes - d0);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r;
    @(negedge clk);
    write_reg(2'd1, 32'h0004_0000);
    write_reg(2'd3, 32'h8000_0000);
    @(negedge clk);
    #1;
    checks++; if (lm_armwrite !== 1'b1) begin errors++; $display("FAIL mid_data_strobe: wr=%b want 1", lm_armwrite); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lm_armwrite, lm_own, lm_armwaddr, lm_armwdata} !== 36'h0) begin
      errors++; $display("FAIL mid_reset_port: wr=%b own=%b waddr=%h wdata=%h want all 0",
                         lm_armwrite, lm_own, lm_armwaddr, lm_armwdata);
    end
    read_reg(2'd3, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL mid_reset_status: got %h want 0", r); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    armwrite = 1'b0; armraddr = 2'd0; armwaddr = 2'd0; armwdata = 32'd0;
    msyn_in_h = 1'b0; lm_ssyn_h = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset;
    test_fill;
    test_sum;
    test_verify;
    test_wrap_stall;
    test_abort;
    test_count_zero;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
